// File: rtl/ppu_bg_fetch_if.sv
// VRAM read port between the background fetcher and the VRAM arbiter.
// The fetcher drives a registered read address and the arbiter returns
// read data that is valid during the cycle after the address changes.
interface ppu_bg_fetch_if;
    logic [13:0] VRAM_addr;
    logic [7:0]  VRAM_data_in;

    modport master (
        output VRAM_addr,
        input  VRAM_data_in
    );

    modport slave (
        input  VRAM_addr,
        output VRAM_data_in
    );
endinterface

// File: rtl/ppu_bg_fetch.sv
// PPU background fetch and shift unit.
// Holds the loopy scroll address v, runs the 8-dot nametable/attribute/
// pattern fetch cycle over the shared VRAM port, and shifts tile data out
// as one 4-bit background palette index per dot.
module ppu_bg_fetch #(
    parameter int VIS_W          = 256,
    parameter int VIS_LINES      = 240,
    parameter int PRE_LINE       = 261,
    parameter int PREFETCH_START = 320,
    parameter int PREFETCH_TILES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x_idx_i,
    input  logic [9:0]  scanline_i,
    input  logic        render_en_i,
    input  logic        show_left8_i,
    input  logic        bg_pt_addr_i,
    input  logic [14:0] t_addr_i,
    input  logic [2:0]  fine_x_i,
    ppu_bg_fetch_if.master vram,
    output logic [3:0]  pixel_o,
    output logic        opaque_o
);

    localparam logic [9:0] VIS_W_C     = 10'(VIS_W);
    localparam logic [9:0] VIS_LAST_C  = 10'(VIS_W - 1);
    localparam logic [9:0] VIS_LINES_C = 10'(VIS_LINES);
    localparam logic [9:0] PRE_LINE_C  = 10'(PRE_LINE);
    localparam logic [9:0] PF_START_C  = 10'(PREFETCH_START);
    localparam logic [9:0] PF_END_C    = 10'(PREFETCH_START + 8 * PREFETCH_TILES);
    localparam logic [9:0] VCOPY_LO_C  = 10'd279;
    localparam logic [9:0] VCOPY_HI_C  = 10'd303;

    // Scroll address, VRAM address and fetch latches
    logic [14:0] v_q, v_d;
    logic [13:0] vramAddr_q, vramAddr_d;
    logic [7:0]  tile_q, tile_d;
    logic [1:0]  attr_q, attr_d;
    logic [7:0]  ptLo_q, ptLo_d;
    logic [7:0]  ptHi_q, ptHi_d;

    // Background shifters; bit 0 is the oldest pixel
    logic [15:0] shPtLo_q, shPtLo_d;
    logic [15:0] shPtHi_q, shPtHi_d;
    logic [15:0] shAtLo_q, shAtLo_d;
    logic [15:0] shAtHi_q, shAtHi_d;

    // Decode helpers
    logic        activeLine;
    logic        inFetchWin;
    logic        fetchEn;
    logic        hCopy;
    logic        vCopy;
    logic [2:0]  phase;
    logic [7:0]  attrShifted;
    logic [3:0]  pixelRaw;
    logic        clip;

    // Pattern bytes arrive MSB = leftmost pixel, but the shifters emit bit 0
    // first, so the byte is mirrored on load.
    function automatic logic [7:0] reverseByte(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

    // Decide whether this dot fetches/shifts and whether a copy rule fires
    always_comb begin
        activeLine = (scanline_i < VIS_LINES_C) || (scanline_i == PRE_LINE_C);
        inFetchWin = (x_idx_i < VIS_W_C) ||
                     ((x_idx_i >= PF_START_C) && (x_idx_i < PF_END_C));
        fetchEn    = render_en_i && activeLine && inFetchWin;
        hCopy      = render_en_i && activeLine && (x_idx_i == VIS_W_C);
        vCopy      = render_en_i && (scanline_i == PRE_LINE_C) &&
                     (x_idx_i >= VCOPY_LO_C) && (x_idx_i <= VCOPY_HI_C);
        phase      = x_idx_i[2:0];
        // Quadrant select inside the attribute byte is {coarseY[1], coarseX[1]}
        attrShifted = vram.VRAM_data_in >> {v_q[6], v_q[1], 1'b0};
    end

    // Next-state for the fetch sequence, shifters and scroll address
    always_comb begin
        v_d        = v_q;
        vramAddr_d = vramAddr_q;
        tile_d     = tile_q;
        attr_d     = attr_q;
        ptLo_d     = ptLo_q;
        ptHi_d     = ptHi_q;
        shPtLo_d   = shPtLo_q;
        shPtHi_d   = shPtHi_q;
        shAtLo_d   = shAtLo_q;
        shAtHi_d   = shAtHi_q;

        if (fetchEn) begin
            shPtLo_d = {1'b0, shPtLo_q[15:1]};
            shPtHi_d = {1'b0, shPtHi_q[15:1]};
            shAtLo_d = {1'b0, shAtLo_q[15:1]};
            shAtHi_d = {1'b0, shAtHi_q[15:1]};

            case (phase)
                3'd0: vramAddr_d = {2'b10, v_q[11:0]};
                3'd1: tile_d = vram.VRAM_data_in;
                3'd2: vramAddr_d = {2'b10, v_q[11:10], 4'b1111, v_q[9:7], v_q[4:2]};
                3'd3: attr_d = attrShifted[1:0];
                3'd4: vramAddr_d = {1'b0, bg_pt_addr_i, tile_q, 1'b0, v_q[14:12]};
                3'd5: begin
                    ptLo_d     = vram.VRAM_data_in;
                    vramAddr_d = {1'b0, bg_pt_addr_i, tile_q, 1'b1, v_q[14:12]};
                end
                3'd6: ptHi_d = vram.VRAM_data_in;
                3'd7: begin
                    // Upper halves take the new tile; lower halves keep shifting
                    shPtLo_d[15:8] = reverseByte(ptLo_q);
                    shPtHi_d[15:8] = reverseByte(ptHi_q);
                    shAtLo_d[15:8] = {8{attr_q[0]}};
                    shAtHi_d[15:8] = {8{attr_q[1]}};
                    if (v_q[4:0] == 5'd31) begin
                        v_d[4:0] = 5'd0;
                        v_d[10]  = ~v_q[10];
                    end else begin
                        v_d[4:0] = v_q[4:0] + 5'd1;
                    end
                end
            endcase

            // Fine/coarse Y step touches only v[14:11] and v[9:5], so it
            // can share the last dot of the line with the coarse X step.
            if (x_idx_i == VIS_LAST_C) begin
                if (v_q[14:12] != 3'd7) begin
                    v_d[14:12] = v_q[14:12] + 3'd1;
                end else begin
                    v_d[14:12] = 3'd0;
                    if (v_q[9:5] == 5'd29) begin
                        v_d[9:5] = 5'd0;
                        v_d[11]  = ~v_q[11];
                    end else if (v_q[9:5] == 5'd31) begin
                        v_d[9:5] = 5'd0;
                    end else begin
                        v_d[9:5] = v_q[9:5] + 5'd1;
                    end
                end
            end
        end

        if (hCopy) begin
            v_d[10]  = t_addr_i[10];
            v_d[4:0] = t_addr_i[4:0];
        end

        if (vCopy) begin
            v_d[14:11] = t_addr_i[14:11];
            v_d[9:5]   = t_addr_i[9:5];
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q        <= '0;
            vramAddr_q <= '0;
            tile_q     <= '0;
            attr_q     <= '0;
            ptLo_q     <= '0;
            ptHi_q     <= '0;
            shPtLo_q   <= '0;
            shPtHi_q   <= '0;
            shAtLo_q   <= '0;
            shAtHi_q   <= '0;
        end else begin
            v_q        <= v_d;
            vramAddr_q <= vramAddr_d;
            tile_q     <= tile_d;
            attr_q     <= attr_d;
            ptLo_q     <= ptLo_d;
            ptHi_q     <= ptHi_d;
            shPtLo_q   <= shPtLo_d;
            shPtHi_q   <= shPtHi_d;
            shAtLo_q   <= shAtLo_d;
            shAtHi_q   <= shAtHi_d;
        end
    end

    assign vram.VRAM_addr = vramAddr_q;

    // Pixel selection by fine X, blanked outside the visible/enabled area
    always_comb begin
        pixelRaw = {shAtHi_q[fine_x_i], shAtLo_q[fine_x_i],
                    shPtHi_q[fine_x_i], shPtLo_q[fine_x_i]};
        clip     = !render_en_i || (x_idx_i >= VIS_W_C) ||
                   (!show_left8_i && (x_idx_i < 10'd8));
        pixel_o  = clip ? 4'd0 : pixelRaw;
        opaque_o = |pixel_o[1:0];
    end

endmodule

// File: tb/tb_ppu_bg_fetch.sv
// Directed testbench for ppu_bg_fetch.
// A small VRAM model answers nametable, attribute and pattern reads from
// programmable bytes; each step drives one dot and compares against
// hand-computed addresses and pixels.
module tb_ppu_bg_fetch;

    localparam int PRE = 261;

    logic        clk;
    logic        reset;
    logic [9:0]  xIdx;
    logic [9:0]  scanline;
    logic        renderEn;
    logic        showLeft8;
    logic        bgPtAddr;
    logic [14:0] tAddr;
    logic [2:0]  fineX;
    logic [3:0]  pixel;
    logic        opaque;

    logic [7:0]  ntByte;
    logic [7:0]  atByte;
    logic [7:0]  ptLoByte;
    logic [7:0]  ptHiByte;

    int total;
    int bad;

    ppu_bg_fetch_if vramBus();

    ppu_bg_fetch #(
        .VIS_W(256),
        .VIS_LINES(240),
        .PRE_LINE(261),
        .PREFETCH_START(320),
        .PREFETCH_TILES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .x_idx_i(xIdx),
        .scanline_i(scanline),
        .render_en_i(renderEn),
        .show_left8_i(showLeft8),
        .bg_pt_addr_i(bgPtAddr),
        .t_addr_i(tAddr),
        .fine_x_i(fineX),
        .vram(vramBus),
        .pixel_o(pixel),
        .opaque_o(opaque)
    );

    // Dot clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational VRAM: attribute table region, nametable, then pattern planes
    always_comb begin
        if (vramBus.VRAM_addr[13]) begin
            if (vramBus.VRAM_addr[9:6] == 4'hF) vramBus.VRAM_data_in = atByte;
            else                                vramBus.VRAM_data_in = ntByte;
        end else if (vramBus.VRAM_addr[3]) begin
            vramBus.VRAM_data_in = ptHiByte;
        end else begin
            vramBus.VRAM_data_in = ptLoByte;
        end
    end

    task automatic applyStimulus(input int x, input int line);
        xIdx     = 10'(x);
        scanline = 10'(line);
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic runDots(input int first, input int last, input int line);
        for (int x = first; x <= last; x++) begin
            applyStimulus(x, line);
            clockEdge();
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAddr(input string tag, input logic [15:0] expected);
        checkOutput(tag, 16'(vramBus.VRAM_addr), expected);
    endtask

    task automatic checkPix(input string tag, input logic [3:0] expPix, input logic expOpq);
        checkOutput(tag, 16'(pixel), 16'(expPix));
        checkOutput({tag, "Opq"}, 16'(opaque), 16'(expOpq));
    endtask

    // Load all of v from t via the horizontal and vertical copy dots
    task automatic loadV(input logic [14:0] t);
        tAddr = t;
        applyStimulus(256, PRE);
        clockEdge();
        applyStimulus(280, PRE);
        clockEdge();
    endtask

    // Directed sequence
    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        renderEn  = 1'b0;
        showLeft8 = 1'b1;
        bgPtAddr  = 1'b0;
        tAddr     = '0;
        fineX     = 3'd0;
        xIdx      = '0;
        scanline  = '0;
        ntByte    = 8'h00;
        atByte    = 8'h00;
        ptLoByte  = 8'h00;
        ptHiByte  = 8'h00;

        clockEdge();
        checkAddr("rstAddr", 16'h0000);
        checkPix("rstPix", 4'h0, 1'b0);
        clockEdge();
        reset    = 1'b0;
        renderEn = 1'b1;

        // Basic fetch sequence from v = 0
        applyStimulus(0, 0); clockEdge(); checkAddr("ntAddr0", 16'h2000);
        runDots(1, 1, 0);
        applyStimulus(2, 0); clockEdge(); checkAddr("atAddr0", 16'h23C0);
        runDots(3, 3, 0);
        applyStimulus(4, 0); clockEdge(); checkAddr("ptLoAddr0", 16'h0000);
        applyStimulus(5, 0); clockEdge(); checkAddr("ptHiAddr0", 16'h0008);
        runDots(6, 7, 0);
        applyStimulus(8, 0); clockEdge(); checkAddr("ntAddr1", 16'h2001);
        ntByte = 8'h41;
        runDots(9, 11, 0);
        applyStimulus(12, 0); clockEdge(); checkAddr("ptLoAddr41", 16'h0410);
        applyStimulus(13, 0); clockEdge(); checkAddr("ptHiAddr41", 16'h0418);
        runDots(14, 15, 0);
        renderEn = 1'b0;
        applyStimulus(16, 0);
        checkPix("offPix", 4'h0, 1'b0);
        clockEdge();
        checkAddr("offAddrHold", 16'h0418);
        renderEn = 1'b1;

        // Coarse X wrap into the next nametable
        ntByte = 8'h00;
        loadV(15'h001F);
        applyStimulus(0, 0); clockEdge(); checkAddr("wrapNt", 16'h201F);
        runDots(1, 1, 0);
        applyStimulus(2, 0); clockEdge(); checkAddr("wrapAt", 16'h23C7);
        runDots(3, 7, 0);
        applyStimulus(8, 0); clockEdge(); checkAddr("wrapNtNext", 16'h2400);

        // Fine Y overflow with coarse Y = 29 toggles v[11]
        ntByte = 8'h12;
        loadV(15'h73A0);
        runDots(255, 255, 0);
        applyStimulus(0, 1); clockEdge(); checkAddr("y29Nt", 16'h2801);
        runDots(1, 3, 1);
        applyStimulus(4, 1); clockEdge(); checkAddr("y29Pt", 16'h0120);

        // Coarse Y = 31 wraps without toggling
        loadV(15'h73E0);
        runDots(255, 255, 0);
        applyStimulus(0, 1); clockEdge(); checkAddr("y31Nt", 16'h2001);

        // Ordinary coarse Y step
        loadV(15'h70A0);
        runDots(255, 255, 0);
        applyStimulus(0, 1); clockEdge(); checkAddr("y5Nt", 16'h20C1);

        // Fine Y step below 7, upper pattern table
        bgPtAddr = 1'b1;
        loadV(15'h1000);
        runDots(255, 255, 0);
        applyStimulus(0, 1); clockEdge(); checkAddr("fy1Nt", 16'h2001);
        runDots(1, 3, 1);
        applyStimulus(4, 1); clockEdge(); checkAddr("fy1Pt", 16'h1122);
        bgPtAddr = 1'b0;

        // Pixel path: PT 0x80/0x00, attribute quadrant 3 of 0xC0
        ntByte   = 8'h00;
        atByte   = 8'hC0;
        ptLoByte = 8'h80;
        ptHiByte = 8'h00;
        loadV(15'h0042);
        runDots(0, 12, 5);
        fineX = 3'd3;
        applyStimulus(13, 5); checkPix("fx3First", 4'hD, 1'b1); clockEdge();
        applyStimulus(14, 5); checkPix("fx3Second", 4'hC, 1'b0); clockEdge();
        runDots(15, 15, 5);
        fineX = 3'd0;
        applyStimulus(16, 5); checkPix("fx0First", 4'hD, 1'b1); clockEdge();
        applyStimulus(17, 5); checkPix("fx0Second", 4'hC, 1'b0); clockEdge();
        applyStimulus(256, 5); checkPix("clipRight", 4'h0, 1'b0);

        // Prefetch primes the next line; left 8 clipping
        atByte = 8'hFF;
        runDots(320, 335, 5);
        showLeft8 = 1'b0;
        applyStimulus(0, 6); checkPix("left8Clip", 4'h0, 1'b0);
        showLeft8 = 1'b1;
        #1;
        checkPix("left8Shown", 4'hD, 1'b1);
        showLeft8 = 1'b0;
        clockEdge();
        runDots(1, 6, 6);
        applyStimulus(7, 6); checkPix("left8Last", 4'h0, 1'b0); clockEdge();
        applyStimulus(8, 6); checkPix("tileBFirst", 4'hD, 1'b1);

        // Render disable mid-line: blank now, hold state across the edge
        renderEn = 1'b0;
        #1;
        checkPix("renderOffPix", 4'h0, 1'b0);
        clockEdge();
        checkAddr("renderOffAddr", 16'h0008);
        renderEn = 1'b1;
        applyStimulus(9, 6); checkPix("retainPix", 4'hD, 1'b1);

        // Asynchronous reset mid-fetch
        reset = 1'b1;
        #1;
        checkAddr("midRstAddr", 16'h0000);
        checkPix("midRstPix", 4'h0, 1'b0);
        clockEdge();
        reset = 1'b0;
        applyStimulus(10, 6); clockEdge(); checkAddr("postRstAt", 16'h23C0);
        runDots(11, 11, 6);
        applyStimulus(12, 6); checkPix("postRstPix", 4'h0, 1'b0);
        clockEdge();
        checkAddr("postRstPt", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
